// File: rtl/riscv_periph_pkg.sv
// Shared definitions for the data-memory peripheral window.
// Holds register offsets (word index within the 16-byte window), STATUS bit
// positions and the UART transmit state encoding.
package riscv_periph_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_EXIT   = 2'd2;

  localparam int unsigned ST_FULL     = 0;
  localparam int unsigned ST_EMPTY    = 1;
  localparam int unsigned ST_BUSY     = 2;
  localparam int unsigned ST_OVF      = 3;
  localparam int unsigned ST_EXITP    = 4;
  localparam int unsigned ST_CNT_LSB  = 8;
  localparam int unsigned ST_CNT_W    = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data.
// Ports: i_push/i_wdata write side, i_pop/o_rdata_c read side,
//        o_full_c/o_empty_c flags (decoded from count), o_count occupancy.
// A push while full or a pop while empty is ignored; push and pop together
// both take effect and leave the count unchanged.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata_c,
  output logic                     o_full_c,
  output logic                     o_empty_c,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata_c = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full_c;
  assign w_do_pop  = i_pop & ~o_empty_c;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/dmem_console_tx.sv
// Console/exit responder in a 16-byte window of the data-memory port.
// Ports: dmem_w* store request, dmem_r* load request with registered
//        dmem_rdata (1-cycle latency), uart_tx 8N1 serial output,
//        exit_valid/exit_code program-exit indication (sticky until reset).
// Stored bytes queue in tx_fifo and are serialized LSB first; exit_valid
// waits until every queued character has left the wire.
module dmem_console_tx
  import riscv_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        dmem_wready,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  input  logic        dmem_rready,
  input  logic [31:0] dmem_raddr,
  output logic [31:0] dmem_rdata,
  output logic        uart_tx,
  output logic        exit_valid,
  output logic [31:0] exit_code
);

  localparam int unsigned CW  = $clog2(CLK_DIV);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

  logic            w_whit, w_rhit;
  logic [1:0]      w_woff, w_roff;
  logic            w_push, w_pop;
  logic [7:0]      w_fifo_rdata;
  logic            w_full, w_empty;
  logic [FCW-1:0]  w_count;
  logic [31:0]     w_status;
  logic            w_unused_ok;

  logic            r_ovf, r_exit_pending, r_exit_valid;
  logic [31:0]     r_exit_code, r_rdata;

  tx_state_e       r_state, w_state_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic [CW-1:0]   r_bitcnt, w_bitcnt_nxt;
  logic [2:0]      r_bitidx, w_bitidx_nxt;
  logic            r_tx, w_tx_nxt;

  // Window decode; the low two address bits do not select anything.
  assign w_whit      = dmem_wready && (dmem_waddr[31:4] == BASE_ADDR[31:4]);
  assign w_rhit      = dmem_rready && (dmem_raddr[31:4] == BASE_ADDR[31:4]);
  assign w_woff      = dmem_waddr[3:2];
  assign w_roff      = dmem_raddr[3:2];
  assign w_push      = w_whit && (w_woff == OFF_TXDATA) && dmem_wstrb[0];
  assign w_unused_ok = ^{dmem_waddr[1:0], dmem_raddr[1:0]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) tx_fifo (
    .clk       (clk),
    .resetb    (resetb),
    .i_push    (w_push),
    .i_wdata   (dmem_wdata[7:0]),
    .i_pop     (w_pop),
    .o_rdata_c (w_fifo_rdata),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (w_count)
  );

  // STATUS word built from current (pre-write) state.
  always_comb begin
    w_status                                = '0;
    w_status[ST_FULL]                       = w_full;
    w_status[ST_EMPTY]                      = w_empty;
    w_status[ST_BUSY]                       = (r_state != TX_IDLE);
    w_status[ST_OVF]                        = r_ovf;
    w_status[ST_EXITP]                      = r_exit_pending;
    w_status[ST_CNT_LSB +: ST_CNT_W]        = ST_CNT_W'(w_count);
  end

  // Control registers and registered load data.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_ovf          <= 1'b0;
      r_exit_pending <= 1'b0;
      r_exit_valid   <= 1'b0;
      r_exit_code    <= '0;
      r_rdata        <= '0;
    end else begin
      if (w_push && w_full) r_ovf <= 1'b1;
      else if (w_whit && (w_woff == OFF_STATUS) && dmem_wdata[ST_OVF]) r_ovf <= 1'b0;
      if (w_whit && (w_woff == OFF_EXIT) && !r_exit_pending && (dmem_wstrb != 4'b0)) begin
        r_exit_code    <= dmem_wdata;
        r_exit_pending <= 1'b1;
      end
      if (r_exit_pending && w_empty && (r_state == TX_IDLE)) r_exit_valid <= 1'b1;
      if (dmem_rready) r_rdata <= (w_rhit && (w_roff == OFF_STATUS)) ? w_status : '0;
    end
  end

  // TX FSM state register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state  <= TX_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_bitidx <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_bitidx <= w_bitidx_nxt;
      r_tx     <= w_tx_nxt;
    end
  end

  // TX FSM next state; w_tx_nxt is the line level for the next cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_bitidx_nxt = r_bitidx;
    w_tx_nxt     = r_tx;
    w_pop        = 1'b0;
    unique case (r_state)
      TX_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_nxt  = w_fifo_rdata;
          w_bitcnt_nxt = CW'(CLK_DIV - 1);
          w_tx_nxt     = 1'b0;
          w_state_nxt  = TX_START;
        end
      end
      TX_START: begin
        if (r_bitcnt == '0) begin
          w_bitcnt_nxt = CW'(CLK_DIV - 1);
          w_bitidx_nxt = 3'd0;
          w_tx_nxt     = r_shift[0];
          w_shift_nxt  = {1'b0, r_shift[7:1]};
          w_state_nxt  = TX_DATA;
        end else begin
          w_bitcnt_nxt = r_bitcnt - CW'(1);
        end
      end
      TX_DATA: begin
        if (r_bitcnt == '0) begin
          w_bitcnt_nxt = CW'(CLK_DIV - 1);
          if (r_bitidx == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = TX_STOP;
          end else begin
            w_bitidx_nxt = r_bitidx + 3'd1;
            w_tx_nxt     = r_shift[0];
            w_shift_nxt  = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_bitcnt_nxt = r_bitcnt - CW'(1);
        end
      end
      TX_STOP: begin
        if (r_bitcnt == '0) begin
          w_tx_nxt    = 1'b1;
          w_state_nxt = TX_IDLE;
        end else begin
          w_bitcnt_nxt = r_bitcnt - CW'(1);
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  assign dmem_rdata = r_rdata;
  assign uart_tx    = r_tx;
  assign exit_valid = r_exit_valid;
  assign exit_code  = r_exit_code;

endmodule
